// File: rtl/vga_scan_timing.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : vga_scan_timing                                                  |
// | Brief   : VGA raster timing with a frame-stable game-state snapshot.       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module vga_scan_timing #(
  parameter int CLK_DIV  = 4,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [47:0] numbers_in,
  input  logic [2:0]  sel1_in,
  input  logic [2:0]  sel2_in,
  input  logic        win_in,
  input  logic        lose_in,
  output logic        pix_en,
  output logic [9:0]  sx,
  output logic [9:0]  sy,
  output logic        hsync,
  output logic        vsync,
  output logic        de,
  output logic        frame_start,
  output logic [47:0] numbers_concat,
  output logic [2:0]  s1,
  output logic [2:0]  s2,
  output logic        win,
  output logic        lose
);

  localparam int C_H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int C_V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int C_DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [C_DIV_W-1:0] C_DIV_LAST = C_DIV_W'(CLK_DIV - 1);
  localparam logic [9:0] C_H_LAST     = 10'(C_H_TOTAL - 1);
  localparam logic [9:0] C_V_LAST     = 10'(C_V_TOTAL - 1);
  localparam logic [9:0] C_H_ACT      = 10'(H_ACTIVE);
  localparam logic [9:0] C_V_ACT      = 10'(V_ACTIVE);
  localparam logic [9:0] C_V_ACT_LAST = 10'(V_ACTIVE - 1);
  localparam logic [9:0] C_HS_BEG     = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] C_HS_END     = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] C_VS_BEG     = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] C_VS_END     = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic [C_DIV_W-1:0] r_div;
  logic [C_DIV_W-1:0] w_div_nxt;
  logic               r_pix_en;
  logic [9:0]         r_sx;
  logic [9:0]         r_sy;
  logic [9:0]         w_sx_nxt;
  logic [9:0]         w_sy_nxt;
  logic               r_hsync;
  logic               r_vsync;
  logic               r_de;
  logic               r_frame_start;
  logic               w_frame_edge;
  logic [47:0]        r_numbers;
  logic [2:0]         r_s1;
  logic [2:0]         r_s2;
  logic               r_win;
  logic               r_lose;

  // pix_en is registered from the next divider value so it lines up with div==CLK_DIV-1.
  assign w_div_nxt = (r_div == C_DIV_LAST) ? '0 : r_div + 1'b1;

  always_comb begin
    w_sx_nxt = r_sx;
    w_sy_nxt = r_sy;
    if (r_pix_en) begin
      if (r_sx == C_H_LAST) begin
        w_sx_nxt = '0;
        w_sy_nxt = (r_sy == C_V_LAST) ? '0 : r_sy + 10'd1;
      end else begin
        w_sx_nxt = r_sx + 10'd1;
      end
    end
  end

  // The edge that moves the raster to (0, V_ACTIVE) opens vblank.
  assign w_frame_edge = r_pix_en && (r_sx == C_H_LAST) && (r_sy == C_V_ACT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div         <= '0;
      r_pix_en      <= 1'b0;
      r_sx          <= '0;
      r_sy          <= '0;
      r_hsync       <= 1'b1;
      r_vsync       <= 1'b1;
      r_de          <= 1'b1;
      r_frame_start <= 1'b0;
    end else begin
      r_div         <= w_div_nxt;
      r_pix_en      <= (w_div_nxt == C_DIV_LAST);
      r_sx          <= w_sx_nxt;
      r_sy          <= w_sy_nxt;
      r_hsync       <= !((w_sx_nxt >= C_HS_BEG) && (w_sx_nxt < C_HS_END));
      r_vsync       <= !((w_sy_nxt >= C_VS_BEG) && (w_sy_nxt < C_VS_END));
      r_de          <= (w_sx_nxt < C_H_ACT) && (w_sy_nxt < C_V_ACT);
      r_frame_start <= w_frame_edge;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_numbers <= 48'hFFFF_FFFF_FFFF;
      r_s1      <= 3'b000;
      r_s2      <= 3'b000;
      r_win     <= 1'b0;
      r_lose    <= 1'b0;
    end else if (w_frame_edge) begin
      r_numbers <= numbers_in;
      r_s1      <= sel1_in;
      r_s2      <= sel2_in;
      r_win     <= win_in;
      r_lose    <= lose_in;
    end
  end

  assign pix_en         = r_pix_en;
  assign sx             = r_sx;
  assign sy             = r_sy;
  assign hsync          = r_hsync;
  assign vsync          = r_vsync;
  assign de             = r_de;
  assign frame_start    = r_frame_start;
  assign numbers_concat = r_numbers;
  assign s1             = r_s1;
  assign s2             = r_s2;
  assign win            = r_win;
  assign lose           = r_lose;

endmodule
`default_nettype wire

// File: tb/tb_vga_scan_timing.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_vga_scan_timing                                               |
// | Brief   : Scoreboard bench for vga_scan_timing on a shrunken raster.       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_vga_scan_timing;

  localparam int D  = 3;
  localparam int HA = 16, HF = 2, HS = 3, HB = 3;
  localparam int VA = 8,  VF = 2, VS = 2, VB = 2;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FR = HT * VT;

  typedef struct {
    logic        pix;
    logic [9:0]  sx, sy;
    logic        hs, vs, de, fs;
    logic [47:0] num;
    logic [2:0]  s1, s2;
    logic        w, l;
    logic        pix1;
    logic [9:0]  sx1, sy1;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [47:0] numbers_in = '0;
  logic [2:0]  sel1_in = '0, sel2_in = '0;
  logic        win_in = 1'b0, lose_in = 1'b0;

  logic        pix_en, hsync, vsync, de, frame_start, win, lose;
  logic [9:0]  sx, sy;
  logic [47:0] numbers_concat;
  logic [2:0]  s1, s2;

  logic        pix_en1, hsync1, vsync1, de1, frame_start1, win1, lose1;
  logic [9:0]  sx1, sy1;
  logic [47:0] numbers_concat1;
  logic [2:0]  s1_1, s2_1;

  vga_scan_timing #(.CLK_DIV(D), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
                    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)) dut (
    .clk(clk), .rst_n(rst_n), .numbers_in(numbers_in), .sel1_in(sel1_in),
    .sel2_in(sel2_in), .win_in(win_in), .lose_in(lose_in), .pix_en(pix_en),
    .sx(sx), .sy(sy), .hsync(hsync), .vsync(vsync), .de(de),
    .frame_start(frame_start), .numbers_concat(numbers_concat), .s1(s1), .s2(s2),
    .win(win), .lose(lose));

  // Undivided instance: one pixel per system clock.
  vga_scan_timing #(.CLK_DIV(1), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
                    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)) dut_div1 (
    .clk(clk), .rst_n(rst_n), .numbers_in(numbers_in), .sel1_in(sel1_in),
    .sel2_in(sel2_in), .win_in(win_in), .lose_in(lose_in), .pix_en(pix_en1),
    .sx(sx1), .sy(sy1), .hsync(hsync1), .vsync(vsync1), .de(de1),
    .frame_start(frame_start1), .numbers_concat(numbers_concat1), .s1(s1_1), .s2(s2_1),
    .win(win1), .lose(lose1));

  always #5 clk = ~clk;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   done     = 1'b0;

  // Reference model state: edges since release, pixels since release.
  int          n, p, k;
  bit          pix_m, fs_m;
  logic [47:0] snap_num;
  logic [2:0]  snap_s1, snap_s2;
  logic        snap_w, snap_l;

  task automatic model_reset();
    n = 0; p = 0; k = 0; pix_m = 1'b0; fs_m = 1'b0;
    snap_num = 48'hFFFF_FFFF_FFFF; snap_s1 = 3'b000; snap_s2 = 3'b000;
    snap_w = 1'b0; snap_l = 1'b0;
  endtask

  task automatic model_edge();
    bit adv;
    if (!rst_n) begin
      model_reset();
      return;
    end
    adv   = pix_m;
    n     = n + 1;
    k     = k + 1;
    pix_m = ((n % D) == D - 1);
    fs_m  = 1'b0;
    if (adv) begin
      p = p + 1;
      if ((p % FR) == VA * HT) begin
        fs_m = 1'b1;
        snap_num = numbers_in; snap_s1 = sel1_in; snap_s2 = sel2_in;
        snap_w = win_in; snap_l = lose_in;
      end
    end
  endtask

  function automatic exp_t expect_now();
    exp_t e;
    int x, y, p1;
    x = p % HT;
    y = (p / HT) % VT;
    e.pix = pix_m;
    e.sx  = 10'(x);
    e.sy  = 10'(y);
    e.hs  = !(x >= HA + HF && x < HA + HF + HS);
    e.vs  = !(y >= VA + VF && y < VA + VF + VS);
    e.de  = (x < HA) && (y < VA);
    e.fs  = fs_m;
    e.num = snap_num; e.s1 = snap_s1; e.s2 = snap_s2; e.w = snap_w; e.l = snap_l;
    p1     = (k > 0) ? k - 1 : 0;
    e.pix1 = (k >= 1);
    e.sx1  = 10'(p1 % HT);
    e.sy1  = 10'((p1 / HT) % VT);
    return e;
  endfunction

  task automatic cycle(input bit release_rst, input bit reset_mid);
    @(posedge clk);
    model_edge();
    sb.push_back(expect_now());
    #2;
    if (reset_mid) begin
      rst_n = 1'b0;
      model_reset();
      sb.delete();
      sb.push_back(expect_now());
    end
    if (release_rst) rst_n = 1'b1;
    numbers_in = 48'({$urandom(), $urandom()});
    sel1_in    = 3'($urandom());
    sel2_in    = 3'($urandom());
    win_in     = 1'($urandom());
    lose_in    = 1'($urandom());
  endtask

  task automatic chk(input string name, input logic [47:0] act, input logic [47:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s at t=%0t: got %h, expected %h", name, $time, act, req);
    end
  endtask

  initial begin : monitor
    exp_t e;
    while (!done) begin
      @(negedge clk);
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL scoreboard_empty at t=%0t: got 0 entries, expected 1", $time);
      end else begin
        e = sb.pop_front();
        chk("pix_en", 48'(pix_en), 48'(e.pix));
        chk("sx", 48'(sx), 48'(e.sx));
        chk("sy", 48'(sy), 48'(e.sy));
        chk("hsync", 48'(hsync), 48'(e.hs));
        chk("vsync", 48'(vsync), 48'(e.vs));
        chk("de", 48'(de), 48'(e.de));
        chk("frame_start", 48'(frame_start), 48'(e.fs));
        chk("numbers_concat", numbers_concat, e.num);
        chk("s1", 48'(s1), 48'(e.s1));
        chk("s2", 48'(s2), 48'(e.s2));
        chk("win", 48'(win), 48'(e.w));
        chk("lose", 48'(lose), 48'(e.l));
        chk("div1_pix_en", 48'(pix_en1), 48'(e.pix1));
        chk("div1_sx", 48'(sx1), 48'(e.sx1));
        chk("div1_sy", 48'(sy1), 48'(e.sy1));
      end
    end
  end

  initial begin : driver
    model_reset();
    repeat (3) cycle(1'b0, 1'b0);
    cycle(1'b1, 1'b0);
    // Several full frames with inputs churning every cycle.
    repeat (3500 + $urandom_range(0, 200)) cycle(1'b0, 1'b0);
    // Asynchronous reset landing between clock edges, mid-frame.
    cycle(1'b0, 1'b1);
    cycle(1'b0, 1'b0);
    cycle(1'b1, 1'b0);
    repeat (1500) cycle(1'b0, 1'b0);
    @(negedge clk);
    #1;
    done = 1'b1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
